// File: rtl/router_nxn.sv
// router_nxn: bit-serial NxN packet router with per-output round-robin allocation and cut-through forwarding.
module router_nxn #(
  parameter int NUM_PORTS  = 16,
  parameter int ADDR_W     = $clog2(NUM_PORTS),
  parameter int PAD_CYCLES = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] din,
  input  logic [NUM_PORTS-1:0] frame_n,
  input  logic [NUM_PORTS-1:0] valid_n,
  output logic [NUM_PORTS-1:0] dout,
  output logic [NUM_PORTS-1:0] valido_n,
  output logic [NUM_PORTS-1:0] frameo_n,
  output logic [NUM_PORTS-1:0] busy_n,
  output logic [NUM_PORTS-1:0] pkt_drop
);
  localparam int CW = $clog2(PAD_CYCLES + ADDR_W + 1);
  typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DROP} st_t;
  st_t                  st_q    [NUM_PORTS];
  st_t                  st_d    [NUM_PORTS];
  logic [ADDR_W-1:0]    addr_q  [NUM_PORTS];
  logic [ADDR_W-1:0]    addr_d  [NUM_PORTS];
  logic [CW-1:0]        cnt_q   [NUM_PORTS];
  logic [CW-1:0]        cnt_d   [NUM_PORTS];
  logic [ADDR_W-1:0]    owner_q [NUM_PORTS];
  logic [ADDR_W-1:0]    ptr_q   [NUM_PORTS];
  logic [ADDR_W-1:0]    win_i   [NUM_PORTS];
  logic [NUM_PORTS-1:0] req     [NUM_PORTS];
  logic [NUM_PORTS-1:0] drop_q, drop_d, gnt_v_q, win_v, fwd, hold;
  logic [NUM_PORTS-1:0] dout_q, valido_q, frameo_q;
  logic [ADDR_W-1:0]    a_cur, own;
  logic [CW-1:0]        pos;
  logic                 a_ok, granted;
  int                   idx;
  // req[j][i]: input i waits in PAD for output j
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++)
      for (int i = 0; i < NUM_PORTS; i++)
        req[j][i] = (st_q[i] == PAD) && !frame_n[i] && (addr_q[i] == ADDR_W'(j));
  end
  always_comb begin
    idx = 0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      win_v[j] = 1'b0;
      win_i[j] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(ptr_q[j]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!win_v[j] && req[j][idx]) begin
          win_v[j] = 1'b1;
          win_i[j] = ADDR_W'(idx);
        end
      end
      fwd[j]  = gnt_v_q[j] && (st_q[owner_q[j]] == DATA);
      hold[j] = st_q[owner_q[j]] inside {PAD, DATA};
    end
  end
  // a grant won on the final pad cycle counts immediately so PAD_CYCLES=1 still routes
  always_comb begin
    a_cur   = '0;
    own     = '0;
    pos     = '0;
    a_ok    = 1'b0;
    granted = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      st_d[i]   = st_q[i];
      addr_d[i] = addr_q[i];
      cnt_d[i]  = cnt_q[i];
      pos       = (st_q[i] == ADDR) ? cnt_q[i] : '0;
      a_cur     = ((st_q[i] == ADDR) ? addr_q[i] : '0) | (ADDR_W'(din[i]) << pos);
      a_ok      = 32'(a_cur) < NUM_PORTS;
      own       = addr_q[i];
      granted   = gnt_v_q[own] ? (owner_q[own] == ADDR_W'(i)) : (win_v[own] && win_i[own] == ADDR_W'(i));
      case (st_q[i])
        IDLE: if (!frame_n[i]) begin
          addr_d[i] = a_cur;
          cnt_d[i]  = (ADDR_W == 1) ? '0 : CW'(1);
          st_d[i]   = (ADDR_W == 1) ? (a_ok ? PAD : DROP) : ADDR;
        end
        ADDR: if (frame_n[i]) st_d[i] = IDLE;
        else begin
          addr_d[i] = a_cur;
          cnt_d[i]  = cnt_q[i] + CW'(1);
          if (cnt_q[i] == CW'(ADDR_W - 1)) begin
            cnt_d[i] = '0;
            st_d[i]  = a_ok ? PAD : DROP;
          end
        end
        PAD: if (frame_n[i]) st_d[i] = IDLE;
        else if (cnt_q[i] == CW'(PAD_CYCLES - 1)) st_d[i] = granted ? DATA : DROP;
        else cnt_d[i] = cnt_q[i] + CW'(1);
        DATA: if (frame_n[i] && !valid_n[i]) st_d[i] = IDLE;
        DROP: if (frame_n[i]) st_d[i] = IDLE;
        default: st_d[i] = IDLE;
      endcase
      drop_d[i] = ((st_q[i] == ADDR || st_q[i] == PAD) && frame_n[i]) || (st_d[i] == DROP && st_q[i] != DROP);
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        st_q[i]    <= IDLE;
        addr_q[i]  <= '0;
        cnt_q[i]   <= '0;
        owner_q[i] <= '0;
        ptr_q[i]   <= '0;
      end
      drop_q   <= '0;
      gnt_v_q  <= '0;
      dout_q   <= '0;
      valido_q <= '1;
      frameo_q <= '1;
    end else begin
      drop_q <= drop_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        st_q[i]   <= st_d[i];
        addr_q[i] <= addr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      for (int j = 0; j < NUM_PORTS; j++) begin
        dout_q[j]   <= fwd[j] & ~valid_n[owner_q[j]] & din[owner_q[j]];
        valido_q[j] <= ~fwd[j] | valid_n[owner_q[j]];
        frameo_q[j] <= ~fwd[j] | frame_n[owner_q[j]];
        if (gnt_v_q[j]) gnt_v_q[j] <= hold[j];
        else if (win_v[j]) begin
          gnt_v_q[j] <= 1'b1;
          owner_q[j] <= win_i[j];
          ptr_q[j]   <= (win_i[j] == ADDR_W'(NUM_PORTS - 1)) ? '0 : win_i[j] + ADDR_W'(1);
        end
      end
    end
  end
  assign dout     = dout_q;
  assign valido_n = valido_q;
  assign frameo_n = frameo_q;
  assign busy_n   = ~gnt_v_q;
  assign pkt_drop = drop_q;
endmodule

// File: tb/tb_router_nxn.sv
// tb_router_nxn: directed tests for router_nxn (16-port instance plus a 12-port instance for address range).
module tb_router_nxn;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] din, frame_n, valid_n, dout, valido_n, frameo_n, busy_n, pkt_drop;
  logic [11:0] din12, frame_n12, valid_n12, dout12, valido_n12, frameo_n12, busy_n12, pkt_drop12;
  int          checks = 0;
  int          failures = 0;
  always #5 clock = ~clock;
  router_nxn #(.NUM_PORTS(16), .PAD_CYCLES(5)) u_dut (
    .clock(clock), .reset_n(reset_n), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .dout(dout), .valido_n(valido_n), .frameo_n(frameo_n), .busy_n(busy_n), .pkt_drop(pkt_drop)
  );
  router_nxn #(.NUM_PORTS(12), .PAD_CYCLES(5)) u_dut12 (
    .clock(clock), .reset_n(reset_n), .din(din12), .frame_n(frame_n12), .valid_n(valid_n12),
    .dout(dout12), .valido_n(valido_n12), .frameo_n(frameo_n12), .busy_n(busy_n12), .pkt_drop(pkt_drop12)
  );
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic idle_all();
    din = '0; frame_n = '1; valid_n = '1;
    din12 = '0; frame_n12 = '1; valid_n12 = '1;
  endtask
  task automatic drive_hdr(input logic [15:0] m, input logic [3:0] a);
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 16; p++) if (m[p]) begin din[p] = a[b]; frame_n[p] = 1'b0; valid_n[p] = 1'b1; end
      step();
    end
  endtask
  task automatic drive_pad(input logic [15:0] m, input int n);
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < 16; p++) if (m[p]) begin din[p] = 1'b1; frame_n[p] = 1'b0; valid_n[p] = 1'b1; end
      step();
    end
  endtask
  task automatic drive_bit(input logic [15:0] m, input logic d, input logic v_n, input logic f_n);
    for (int p = 0; p < 16; p++) if (m[p]) begin din[p] = d; valid_n[p] = v_n; frame_n[p] = f_n; end
    step();
  endtask
  task automatic test_reset();
    idle_all();
    reset_n = 1'b0;
    #12;
    checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    checks++; if (valido_n !== 16'hFFFF) begin failures++; $display("FAIL reset_valido got=%h exp=ffff", valido_n); end
    checks++; if (frameo_n !== 16'hFFFF) begin failures++; $display("FAIL reset_frameo got=%h exp=ffff", frameo_n); end
    checks++; if (busy_n !== 16'hFFFF) begin failures++; $display("FAIL reset_busy got=%h exp=ffff", busy_n); end
    checks++; if (pkt_drop !== 16'h0000) begin failures++; $display("FAIL reset_drop got=%h exp=0000", pkt_drop); end
    checks++; if ({busy_n12, valido_n12, pkt_drop12} !== {12'hFFF, 12'hFFF, 12'h000}) begin failures++; $display("FAIL reset_dut12 got=%h exp=ffffff000", {busy_n12, valido_n12, pkt_drop12}); end
    #1 reset_n = 1'b1;
    step();
  endtask
  task automatic test_route();
    logic [7:0] pay = 8'b10110011;
    drive_hdr(16'h0008, 4'hA);
    drive_pad(16'h0008, 1);
    checks++; if (busy_n !== 16'hFBFF) begin failures++; $display("FAIL route_busy_low got=%h exp=fbff", busy_n); end
    drive_pad(16'h0008, 4);
    for (int k = 0; k < 8; k++) begin
      drive_bit(16'h0008, pay[7-k], 1'b0, k == 7);
      checks++; if ({dout[10], valido_n[10], frameo_n[10]} !== {pay[7-k], 1'b0, k == 7}) begin failures++; $display("FAIL route_bit%0d got=%b exp=%b", k, {dout[10], valido_n[10], frameo_n[10]}, {pay[7-k], 1'b0, k == 7}); end
    end
    checks++; if (busy_n[10] !== 1'b0) begin failures++; $display("FAIL route_busy_last got=%b exp=0", busy_n[10]); end
    drive_bit(16'h0008, 1'b0, 1'b1, 1'b1);
    checks++; if ({busy_n, valido_n[10]} !== {16'hFFFF, 1'b1}) begin failures++; $display("FAIL route_release got=%h exp=1ffff", {busy_n, valido_n[10]}); end
  endtask
  task automatic test_arbitration();
    logic [15:0] m = 16'h0222;
    drive_hdr(m, 4'd4);
    drive_pad(m, 1);
    checks++; if (busy_n !== 16'hFFEF) begin failures++; $display("FAIL arb_busy got=%h exp=ffef", busy_n); end
    drive_pad(m, 4);
    checks++; if (pkt_drop !== 16'h0220) begin failures++; $display("FAIL arb_drop1 got=%h exp=0220", pkt_drop); end
    din[1] = 1'b1; valid_n[1] = 1'b0; frame_n = '1; din[5] = 1'b0; din[9] = 1'b0;
    step();
    checks++; if ({dout[4], valido_n[4], frameo_n[4], pkt_drop} !== {3'b101, 16'h0000}) begin failures++; $display("FAIL arb_fwd1 got=%h exp=%h", {dout[4], valido_n[4], frameo_n[4], pkt_drop}, {3'b101, 16'h0000}); end
    idle_all();
    step();
    checks++; if (busy_n !== 16'hFFFF) begin failures++; $display("FAIL arb_free got=%h exp=ffff", busy_n); end
    drive_hdr(m, 4'd4);
    drive_pad(m, 5);
    checks++; if (pkt_drop !== 16'h0202) begin failures++; $display("FAIL arb_drop2 got=%h exp=0202", pkt_drop); end
    din = '0; din[5] = 1'b1; valid_n[5] = 1'b0; frame_n = '1;
    step();
    checks++; if ({dout[4], valido_n[4], frameo_n[4]} !== 3'b101) begin failures++; $display("FAIL arb_fwd2 got=%b exp=101", {dout[4], valido_n[4], frameo_n[4]}); end
    idle_all();
    step();
  endtask
  task automatic test_gaps();
    logic [6:0] dv = 7'b1111011;
    logic [6:0] vv = 7'b0011010;
    logic [6:0] fv = 7'b1000000;
    logic [6:0] ed = 7'b1100001;
    drive_hdr(16'h0001, 4'd2);
    drive_pad(16'h0001, 5);
    for (int k = 0; k < 7; k++) begin
      drive_bit(16'h0001, dv[k], vv[k], fv[k]);
      checks++; if ({dout[2], valido_n[2], frameo_n[2]} !== {ed[k], vv[k], fv[k]}) begin failures++; $display("FAIL gaps_bit%0d got=%b exp=%b", k, {dout[2], valido_n[2], frameo_n[2]}, {ed[k], vv[k], fv[k]}); end
    end
    idle_all();
    step();
    step();
    checks++; if (busy_n !== 16'hFFFF) begin failures++; $display("FAIL gaps_release got=%h exp=ffff", busy_n); end
  endtask
  task automatic test_bad_addr();
    logic [3:0] a = 4'd13;
    for (int b = 0; b < 4; b++) begin
      din12[2] = a[b]; frame_n12[2] = 1'b0; valid_n12[2] = 1'b1;
      step();
      if (b == 2) begin
        checks++; if (pkt_drop12 !== 12'h000) begin failures++; $display("FAIL badaddr_early got=%h exp=000", pkt_drop12); end
      end
    end
    checks++; if (pkt_drop12 !== 12'h004) begin failures++; $display("FAIL badaddr_drop got=%h exp=004", pkt_drop12); end
    for (int c = 0; c < 7; c++) begin
      din12[2] = 1'b1; valid_n12[2] = (c < 5); frame_n12[2] = (c == 6);
      step();
      checks++; if ({busy_n12, valido_n12, frameo_n12, pkt_drop12} !== {12'hFFF, 12'hFFF, 12'hFFF, 12'h000}) begin failures++; $display("FAIL badaddr_quiet%0d got=%h exp=fffffffff000", c, {busy_n12, valido_n12, frameo_n12, pkt_drop12}); end
    end
    idle_all();
    step();
  endtask
  task automatic test_abort();
    logic [15:0] m = 16'h0040;
    drive_hdr(m, 4'd7);
    drive_pad(m, 1);
    frame_n[6] = 1'b1; valid_n[6] = 1'b1;
    step();
    checks++; if (pkt_drop !== 16'h0040) begin failures++; $display("FAIL abort_drop got=%h exp=0040", pkt_drop); end
    drive_hdr(m, 4'd8);
    checks++; if ({pkt_drop, busy_n} !== {16'h0000, 16'hFFFF}) begin failures++; $display("FAIL abort_recover got=%h exp=0000ffff", {pkt_drop, busy_n}); end
    drive_pad(m, 5);
    drive_bit(m, 1'b0, 1'b0, 1'b0);
    checks++; if ({dout[8], valido_n[8], frameo_n[8]} !== 3'b000) begin failures++; $display("FAIL abort_next_b0 got=%b exp=000", {dout[8], valido_n[8], frameo_n[8]}); end
    drive_bit(m, 1'b1, 1'b0, 1'b1);
    checks++; if ({dout[8], valido_n[8], frameo_n[8]} !== 3'b101) begin failures++; $display("FAIL abort_next_b1 got=%b exp=101", {dout[8], valido_n[8], frameo_n[8]}); end
    idle_all();
    step();
  endtask
  task automatic test_reset_mid();
    logic [15:0] m = 16'h1000;
    drive_hdr(m, 4'd1);
    drive_pad(m, 5);
    drive_bit(m, 1'b1, 1'b0, 1'b0);
    drive_bit(m, 1'b1, 1'b0, 1'b0);
    checks++; if ({busy_n, dout[1], valido_n[1], frameo_n[1]} !== {16'hFFFD, 3'b100}) begin failures++; $display("FAIL rstmid_busy got=%h exp=%h", {busy_n, dout[1], valido_n[1], frameo_n[1]}, {16'hFFFD, 3'b100}); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({dout, valido_n, frameo_n, busy_n, pkt_drop} !== {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000}) begin failures++; $display("FAIL rstmid_outputs got=%h exp=0000ffffffffffff0000", {dout, valido_n, frameo_n, busy_n, pkt_drop}); end
    idle_all();
    #3 reset_n = 1'b1;
    step();
    checks++; if ({pkt_drop, busy_n} !== {16'h0000, 16'hFFFF}) begin failures++; $display("FAIL rstmid_after got=%h exp=0000ffff", {pkt_drop, busy_n}); end
    drive_hdr(m, 4'd1);
    drive_pad(m, 5);
    drive_bit(m, 1'b1, 1'b0, 1'b1);
    checks++; if ({dout[1], valido_n[1], frameo_n[1]} !== 3'b101) begin failures++; $display("FAIL rstmid_reroute got=%b exp=101", {dout[1], valido_n[1], frameo_n[1]}); end
    idle_all();
    step();
    step();
    checks++; if (busy_n !== 16'hFFFF) begin failures++; $display("FAIL rstmid_release got=%h exp=ffff", busy_n); end
  endtask
  initial begin
    test_reset();
    test_route();
    test_arbitration();
    test_gaps();
    test_bad_addr();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
